audio_echo: RTL
===============

Name: audio_echo

Overview:
- Sample-rate echo/delay effect stage that sits between the codec deserialiser outputs (audio_inL/R) and the registers that feed the serialiser (DSP_outL/R).
- Runs on the 50 MHz system clock.
- Detects each audio frame from the codec LR clock, mixes the incoming stereo sample with a decayed copy from DELAY samples earlier, and stores the result in an on-chip circular buffer, so echoes repeat.

Parameters:
- DEPTH, 4096: buffer depth in stereo frames; must be a power of 2.
- AW, 12: address width; must equal log2(DEPTH).

Ports:
- iCLK  in  1  50 MHz system clock.
- iRST_N  in  1  Asynchronous active-low reset.
- iLRCK  in  1  Codec LR clock, asynchronous to iCLK.
- iIN_L  in  16  Left input sample, signed two's complement; stable around the LRCK rising edge.
- iIN_R  in  16  Right input sample, signed.
- iEN  in  1  1 = echo enabled; 0 = bypass.
- iDELAY  in  AW  Echo delay in frames.
- iDECAY  in  2  Echo attenuation; gain = 2^-(iDECAY+1).
- oOUT_L  out  16  Processed left sample, signed.
- oOUT_R  out  16  Processed right sample, signed.
- oVALID  out  1  One-cycle pulse when oOUT_L/R update.
- oDROP  out  1  One-cycle pulse when a frame tick is lost because the pipeline was busy.

Behaviour:
- Reset (asynchronous, iRST_N=0): state IDLE, wr_ptr=0, fill=0, sync flops=0, oOUT_L=oOUT_R=0, oVALID=0, oDROP=0. Buffer RAM contents are not reset.
- Tick generation:
  - iLRCK passes through a 2-flop synchroniser plus one history flop.
  - tick = synced & ~history, i.e. one cycle per LRCK rising edge.
- States: IDLE -> RD -> CALC -> WR -> IDLE, one cycle each.
- IDLE:
  - On tick, latch iIN_L, iIN_R, iEN, iDECAY.
  - Latch d = (iDELAY==0) ? 1 : iDELAY.
  - Drive rd_addr = (wr_ptr - d) mod DEPTH. Next state RD.
- RD: synchronous RAM read; data is available at the end of the cycle.
- CALC:
  - echo = (fill >= d) ? (mem_data >>> (iDECAY+1)) : 0. The shift is arithmetic, per channel.
  - sum = sign-extended 17-bit in + echo.
  - Saturate sum to [-32768, 32767].
  - If iEN=0, result = in; echo is ignored but still computed.
- WR:
  - mem[wr_ptr] <= {result_L, result_R}.
  - wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0.
  - fill <= min(fill+1, DEPTH).
  - oOUT_L/R <= result; oVALID <= 1 for one cycle.
- Latency: if tick is high in cycle T, oVALID is high and oOUT holds the new value in cycle T+4. oOUT holds its value between updates.
- Tick while state != IDLE: frame ignored, no buffer write, oDROP pulses in the same cycle. This cannot occur at 48 kHz but must be handled.
- Bypass still writes the dry input to the buffer, so enabling echo mid-stream immediately gives valid history.
- Read and write never collide: with d>=1, rd_addr != wr_ptr.
- fill gating: the echo is masked until d frames have been written since reset. If iDELAY changes to a value above fill, the echo is masked again until fill catches up.
- Delays: d = DEPTH-1 is the maximum. iDELAY=0 behaves as 1.
- Reset mid-frame aborts the operation with no write; fill returns to 0.

Test Plan:
- Reset, then 3 LRCK edges, iEN=1, iDELAY=4, iIN_L=0x1000 -> oOUT_L=0x1000 each frame (echo masked, fill<4); oVALID exactly 4 cycles after each tick.
- iEN=1, iDELAY=1, iDECAY=0, constant iIN_L=0x1000 from reset:
  - outputs 0x1000, 0x1800, 0x1C00, 0x1E00 converge toward 0x2000.
  - iIN_R=-0x1000 gives the negated sequence (arithmetic shift check).
- Saturation: iDELAY=1, iDECAY=0, iIN_L=0x7000 repeated -> second output 0x7FFF, not wrapped. iIN_L=0x9000 repeated -> 0x8000.
- Bypass: iEN=0, random inputs for 10 frames -> oOUT equals the latched input. Then iEN=1, iDELAY=2, iDECAY=1 -> output = in + (in from 2 frames earlier)>>>2.
- Wrap: DEPTH=16 build, iDELAY=15, impulse 0x4000 then zeros, iDECAY=0 -> 0x2000 appears exactly 15 frames later, then 0x1000 after another 15 frames, across the wr_ptr wrap.
- LRCK edges 2 cycles apart, forced by the bench -> second tick asserts oDROP, one output only. Assert iRST_N low between RD and WR -> no oVALID, outputs 0, fill restarts at 0.

Source files
------------

// File: rtl/audio_echo.sv
// Frame-rate stereo echo: mixes each LRCK frame with a decayed copy from
// d frames earlier and stores the mix in a circular buffer so echoes repeat.
module audio_echo #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iLRCK,
    input  logic signed [15:0] iIN_L,
    input  logic signed [15:0] iIN_R,
    input  logic               iEN,
    input  logic [AW-1:0]      iDELAY,
    input  logic [1:0]         iDECAY,
    output logic signed [15:0] oOUT_L,
    output logic signed [15:0] oOUT_R,
    output logic               oVALID,
    output logic               oDROP
);

    typedef enum logic [1:0] {IDLE, RD, CALC, WR} state_t;

    localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] ONE      = {{(AW-1){1'b0}}, 1'b1};

    function automatic logic signed [15:0] echo_tap(input logic signed [15:0] x,
                                                    input logic [1:0] dec);
        return x >>> ({1'b0, dec} + 3'd1);
    endfunction

    function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15])
            return s[16] ? 16'sh8000 : 16'sh7FFF;
        return s[15:0];
    endfunction

    logic          lrck_s1, lrck_s2, lrck_hist;
    logic          tick;
    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   fill_q;
    logic [AW-1:0] d_next;

    logic signed [15:0] in_l_p0, in_r_p0;
    logic               en_p0;
    logic [1:0]         decay_p0;
    logic [AW-1:0]      d_p0, rd_addr_p0;
    logic [31:0]        mem_q_p1;
    logic signed [15:0] res_l_p2, res_r_p2;

    logic [31:0]        mem [DEPTH];

    logic               echo_on;
    logic signed [15:0] echo_l, echo_r, res_l, res_r;

    assign tick   = lrck_s2 & ~lrck_hist;
    assign oDROP  = tick && (state_q != IDLE);
    assign d_next = (iDELAY == '0) ? ONE : iDELAY;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = RD;
            RD:      state_d = CALC;
            CALC:    state_d = WR;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            lrck_s1   <= 1'b0;
            lrck_s2   <= 1'b0;
            lrck_hist <= 1'b0;
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            oOUT_L    <= '0;
            oOUT_R    <= '0;
            oVALID    <= 1'b0;
        end else begin
            lrck_s1   <= iLRCK;
            lrck_s2   <= lrck_s1;
            lrck_hist <= lrck_s2;
            state_q   <= state_d;
            oVALID    <= 1'b0;
            if (state_q == WR) begin
                wr_ptr_q <= wr_ptr_q + ONE;
                if (fill_q != FILL_MAX)
                    fill_q <= fill_q + 1'b1;
                oOUT_L <= res_l_p2;
                oOUT_R <= res_r_p2;
                oVALID <= 1'b1;
            end
        end
    end

    // p0: frame capture and read address (d >= 1 keeps rd_addr off wr_ptr)
    always_ff @(posedge iCLK) begin
        if (state_q == IDLE && tick) begin
            in_l_p0    <= iIN_L;
            in_r_p0    <= iIN_R;
            en_p0      <= iEN;
            decay_p0   <= iDECAY;
            d_p0       <= d_next;
            rd_addr_p0 <= wr_ptr_q - d_next;
        end
    end

    // p1: buffer access, read in RD and write in WR
    always_ff @(posedge iCLK) begin
        if (state_q == RD)
            mem_q_p1 <= mem[rd_addr_p0];
        if (state_q == WR)
            mem[wr_ptr_q] <= {res_l_p2, res_r_p2};
    end

    // Echo is masked until d frames of history exist since reset.
    assign echo_on = (fill_q >= {1'b0, d_p0});
    assign echo_l  = echo_on ? echo_tap(mem_q_p1[31:16], decay_p0) : 16'sd0;
    assign echo_r  = echo_on ? echo_tap(mem_q_p1[15:0],  decay_p0) : 16'sd0;
    assign res_l   = en_p0 ? sat_add(in_l_p0, echo_l) : in_l_p0;
    assign res_r   = en_p0 ? sat_add(in_r_p0, echo_r) : in_r_p0;

    // p2: mixed result held for the write-back cycle
    always_ff @(posedge iCLK) begin
        if (state_q == CALC) begin
            res_l_p2 <= res_l;
            res_r_p2 <= res_r;
        end
    end

endmodule
